// File: rtl/add4_core_if.sv
// Operand/result bundle for the 4-bit adder leaf; the master drives operands,
// the slave (add4_core) returns combinational and registered results.
interface add4_core_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             en;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             P;
    logic             G;
    logic             Ovf;
    logic [WIDTH-1:0] Sum_q;
    logic             Cout_q;
    logic             Ovf_q;

    modport master (
        output A, B, Cin, en,
        input  Sum, Cout, P, G, Ovf, Sum_q, Cout_q, Ovf_q
    );

    modport slave (
        input  A, B, Cin, en,
        output Sum, Cout, P, G, Ovf, Sum_q, Cout_q, Ovf_q
    );
endinterface

// File: rtl/add4_core.sv
// 4-bit ripple-carry adder with group propagate/generate, signed overflow,
// and an enable-gated registered copy of Sum/Cout/Ovf.
module add4_core #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    add4_core_if.slave   bus
);
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH:0]   w_c;
    logic             w_ovf;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    assign w_c[0] = bus.Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign w_p[i]   = bus.A[i] ^ bus.B[i];
        assign w_g[i]   = bus.A[i] & bus.B[i];
        assign w_s[i]   = w_p[i] ^ w_c[i];
        assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end

    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    assign w_ovf = w_c[WIDTH-1] ^ w_c[WIDTH];

    assign bus.Sum  = w_s;
    assign bus.Cout = w_c[WIDTH];
    assign bus.Ovf  = w_ovf;
    assign bus.P    = &w_p;
    assign bus.G    = w_g[3]
                    | (w_p[3] & w_g[2])
                    | (w_p[3] & w_p[2] & w_g[1])
                    | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    // NOTE: non-blocking assignments keep the capture ordered against other
    // clocked logic reading these registers in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (bus.en) begin
            r_sum  <= w_s;
            r_cout <= w_c[WIDTH];
            r_ovf  <= w_ovf;
        end
    end

    assign bus.Sum_q  = r_sum;
    assign bus.Cout_q = r_cout;
    assign bus.Ovf_q  = r_ovf;
endmodule

// File: tb/tb_add4_core.sv
// Self-checking bench for add4_core: exhaustive combinational sweep against a
// behavioural model, directed boundary vectors, and registered-path checks.
module tb_add4_core;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    add4_core_if #(.WIDTH(4)) bus ();

    add4_core #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin);
        bus.A   = a;
        bus.B   = b;
        bus.Cin = cin;
        #2;
    endtask

    initial begin
        logic [4:0] total;
        logic       exp_p;
        logic       exp_g;
        logic       exp_ovf;
        n_checks = 0;
        n_fails  = 0;

        rst_n  = 1'b0;
        bus.en = 1'b0;
        bus.A  = 4'd0;
        bus.B  = 4'd0;
        bus.Cin = 1'b0;
        #1;
        check("reset_sum_q",  {4'd0, bus.Sum_q}, 8'd0);
        check("reset_cout_q", {7'd0, bus.Cout_q}, 8'd0);
        check("reset_ovf_q",  {7'd0, bus.Ovf_q}, 8'd0);

        // Exhaustive combinational sweep against an arithmetic model.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    drive(4'(a), 4'(b), 1'(c));
                    total   = 5'(a + b + c);
                    exp_p   = ((a ^ b) == 15);
                    exp_g   = ((a + b) > 15);
                    exp_ovf = (a[3] == b[3]) && (total[3] != a[3]);
                    check("exh_sum_cout", {3'd0, bus.Cout, bus.Sum}, {3'd0, total});
                    check("exh_p",   {7'd0, bus.P},   {7'd0, exp_p});
                    check("exh_g",   {7'd0, bus.G},   {7'd0, exp_g});
                    check("exh_ovf", {7'd0, bus.Ovf}, {7'd0, exp_ovf});
                end
            end
        end

        // Directed vectors with hand-computed results.
        drive(4'd2, 4'd2, 1'b0);
        check("d_2p2_sum",  {4'd0, bus.Sum}, 8'd4);
        check("d_2p2_cout", {7'd0, bus.Cout}, 8'd0);
        check("d_2p2_ovf",  {7'd0, bus.Ovf}, 8'd0);
        drive(4'd15, 4'd0, 1'b1);
        check("d_15p0p1_sum",  {4'd0, bus.Sum}, 8'd0);
        check("d_15p0p1_cout", {7'd0, bus.Cout}, 8'd1);
        check("d_15p0p1_p",    {7'd0, bus.P}, 8'd1);
        check("d_15p0p1_g",    {7'd0, bus.G}, 8'd0);
        drive(4'd2, 4'd4, 1'b1);
        check("d_2p4p1_sum",  {4'd0, bus.Sum}, 8'd7);
        check("d_2p4p1_cout", {7'd0, bus.Cout}, 8'd0);
        drive(4'd15, 4'd15, 1'b1);
        check("d_15p15p1_sum",  {4'd0, bus.Sum}, 8'd15);
        check("d_15p15p1_cout", {7'd0, bus.Cout}, 8'd1);
        drive(4'd0, 4'd0, 1'b0);
        check("d_zero_sum",  {4'd0, bus.Sum}, 8'd0);
        check("d_zero_cout", {7'd0, bus.Cout}, 8'd0);
        check("d_zero_p",    {7'd0, bus.P}, 8'd0);
        check("d_zero_g",    {7'd0, bus.G}, 8'd0);
        drive(4'd7, 4'd1, 1'b0);
        check("d_7p1_sum",  {4'd0, bus.Sum}, 8'd8);
        check("d_7p1_cout", {7'd0, bus.Cout}, 8'd0);
        check("d_7p1_ovf",  {7'd0, bus.Ovf}, 8'd1);
        drive(4'd8, 4'd8, 1'b0);
        check("d_8p8_sum",  {4'd0, bus.Sum}, 8'd0);
        check("d_8p8_cout", {7'd0, bus.Cout}, 8'd1);
        check("d_8p8_ovf",  {7'd0, bus.Ovf}, 8'd1);
        check("d_8p8_g",    {7'd0, bus.G}, 8'd1);
        drive(4'd5, 4'd10, 1'b0);
        check("d_5p10_p",    {7'd0, bus.P}, 8'd1);
        check("d_5p10_g",    {7'd0, bus.G}, 8'd0);
        check("d_5p10_cout", {7'd0, bus.Cout}, 8'd0);

        // Registers must still be clear: reset held through the sweep.
        check("held_reset_sum_q", {4'd0, bus.Sum_q}, 8'd0);

        // Release reset and capture 9+9+1 = 19 -> Sum_q=3, Cout_q=1, Ovf_q=1.
        @(negedge clk);
        rst_n  = 1'b1;
        bus.en = 1'b1;
        drive(4'd9, 4'd9, 1'b1);
        check("pre_edge_sum_q", {4'd0, bus.Sum_q}, 8'd0);
        @(posedge clk);
        #1;
        check("cap_sum_q",  {4'd0, bus.Sum_q}, 8'd3);
        check("cap_cout_q", {7'd0, bus.Cout_q}, 8'd1);
        check("cap_ovf_q",  {7'd0, bus.Ovf_q}, 8'd1);

        // Hold with en=0 while inputs change.
        @(negedge clk);
        bus.en = 1'b0;
        drive(4'd1, 4'd1, 1'b0);
        @(posedge clk);
        #1;
        check("hold_sum_q",  {4'd0, bus.Sum_q}, 8'd3);
        check("hold_cout_q", {7'd0, bus.Cout_q}, 8'd1);
        check("hold_comb_sum", {4'd0, bus.Sum}, 8'd2);

        // Capture 7+1 = 8 with overflow.
        @(negedge clk);
        bus.en = 1'b1;
        drive(4'd7, 4'd1, 1'b0);
        @(posedge clk);
        #1;
        check("cap2_sum_q",  {4'd0, bus.Sum_q}, 8'd8);
        check("cap2_cout_q", {7'd0, bus.Cout_q}, 8'd0);
        check("cap2_ovf_q",  {7'd0, bus.Ovf_q}, 8'd1);

        // Asynchronous reset between edges clears registers only.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_sum_q",  {4'd0, bus.Sum_q}, 8'd0);
        check("async_ovf_q",  {7'd0, bus.Ovf_q}, 8'd0);
        check("async_comb_sum", {4'd0, bus.Sum}, 8'd8);
        drive(4'd3, 4'd1, 1'b0);
        check("async_comb_track", {4'd0, bus.Sum}, 8'd4);
        @(posedge clk);
        #1;
        check("reset_edge_sum_q", {4'd0, bus.Sum_q}, 8'd0);

        // First capture after release.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rel_sum_q", {4'd0, bus.Sum_q}, 8'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/add4_core.md
Name: add4_core

Overview:
- 4-bit binary adder with carry-in and carry-out.
- Combinational Sum/Cout, valid within one settle period of input change; plus group propagate/generate, signed overflow, and a registered (pipelined) copy of the result.
- Used as an arithmetic leaf block in datapaths and cascadable via Cin/Cout or P/G into wider adders.

Parameters:
- WIDTH, 4, operand width; must stay 4 for this block. Present only for uniform generate loops.

Ports:
- clk  input  1  rising-edge clock for the registered result outputs
- rst_n  input  1  asynchronous active-low reset for the registered outputs
- A  input  4  operand A (unsigned; also interpreted as two's complement for Ovf)
- B  input  4  operand B
- Cin  input  1  carry in
- en  input  1  register load enable for the registered outputs
- Sum  output  4  combinational sum bits, (A+B+Cin) mod 16
- Cout  output  1  combinational carry out, bit 4 of A+B+Cin
- P  output  1  group propagate, AND of (A[i] XOR B[i]) over i=0..3
- G  output  1  group generate, carry out of the block when Cin=0
- Ovf  output  1  combinational signed overflow, carry into bit 3 XOR Cout
- Sum_q  output  4  registered Sum
- Cout_q  output  1  registered Cout
- Ovf_q  output  1  registered Ovf

Behaviour:
- Combinational path:
  - Sum, Cout, P, G and Ovf are purely combinational in A, B and Cin. They do not depend on clk, rst_n or en.
  - {Cout,Sum} = A + B + Cin exactly, as a 5-bit result, for all 512 input combinations.
  - Structure is ripple carry of four full adders.
  - Per bit: p[i]=A[i]^B[i], g[i]=A[i]&B[i], s[i]=p[i]^c[i], c[i+1]=g[i]|(p[i]&c[i]), with c[0]=Cin and Cout=c[4].
  - G = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0.
  - Cout == G | (P & Cin) must always hold.
  - Ovf = c[3]^c[4]. It is set when A and B have equal sign bits and Sum[3] differs, accounting for Cin.
  - No X on any output when inputs are known. Outputs settle within one combinational delay, well under a 10 ns stimulus period.
- Registered path:
  - rst_n low, asynchronously and regardless of clk: Sum_q=0, Cout_q=0, Ovf_q=0.
  - Reset asserted mid-operation clears the registers immediately. The combinational outputs are unaffected.
  - On rising clk with rst_n high and en=1: Sum_q<=Sum, Cout_q<=Cout, Ovf_q<=Ovf, giving 1-cycle latency.
  - With en=0, registers hold their value.
  - Release of rst_n: the first capture happens on the first rising edge with rst_n high and en=1.
  - Input change and clock edge in the same timestep: the register captures the settled value of the combinational result computed from the inputs present before the edge.
- Boundary conditions:
  - 15+0+1 wraps to Sum=0, Cout=1.
  - 15+15+1 gives Sum=15, Cout=1.
  - 0+0+0 gives Sum=0, Cout=0, P=0, G=0.

Test Plan:
- Exhaustive: A=0..15, B=0..15, Cin=0..1, 10 ns per vector. Sum must === (A+B+Cin)[3:0] and Cout === (A+B+Cin)[4]. Stop on the first mismatch.
- Directed vectors:
  - A=2, B=2, Cin=0 -> Sum=4, Cout=0, Ovf=0.
  - A=15, B=0, Cin=1 -> Sum=0, Cout=1, P=1, G=0.
  - A=2, B=4, Cin=1 -> Sum=7, Cout=0.
- Overflow and group signals:
  - A=7, B=1, Cin=0 -> Sum=8, Cout=0, Ovf=1.
  - A=8, B=8, Cin=0 -> Sum=0, Cout=1, Ovf=1, G=1.
  - A=5, B=10, Cin=0 -> P=1, G=0, Cout=0.
- Registered path:
  - rst_n=0 -> Sum_q=0, Cout_q=0, Ovf_q=0 with no clock edge.
  - Release rst_n, en=1, A=9, B=9, Cin=1 -> after 1 rising edge Sum_q=3, Cout_q=1.
  - Set en=0 and change inputs -> Sum_q holds 3.
- Reset mid-operation: with Sum_q nonzero, pulse rst_n low between clock edges -> registers clear immediately while Sum still tracks the inputs.
